// File: rtl/hex7seg_frame_pkg.sv
// Shared definitions for the 4-digit 7-segment frame stage.
// Segment bit order is {dp,g,f,e,d,c,b,a}, and patterns are active-high.
package hex7seg_frame_pkg;
  localparam int NUM_DIGITS = 4;
  localparam logic [7:0] SEG_OFF_HI = 8'h00;

  typedef struct packed {
    logic       dp;
    logic [3:0] nib;
  } digit_t;

  // Hex glyphs, with b and d in lowercase.
  function automatic logic [6:0] hex_glyph(input logic [3:0] n);
    case (n)
      4'h0: hex_glyph = 7'h3F;
      4'h1: hex_glyph = 7'h06;
      4'h2: hex_glyph = 7'h5B;
      4'h3: hex_glyph = 7'h4F;
      4'h4: hex_glyph = 7'h66;
      4'h5: hex_glyph = 7'h6D;
      4'h6: hex_glyph = 7'h7D;
      4'h7: hex_glyph = 7'h07;
      4'h8: hex_glyph = 7'h7F;
      4'h9: hex_glyph = 7'h6F;
      4'hA: hex_glyph = 7'h77;
      4'hB: hex_glyph = 7'h7C;
      4'hC: hex_glyph = 7'h39;
      4'hD: hex_glyph = 7'h5E;
      4'hE: hex_glyph = 7'h79;
      default: hex_glyph = 7'h71;
    endcase
  endfunction
endpackage

// File: rtl/hex7seg_decode.sv
// Combinational digit decoder.
// Converts one nibble plus its decimal point into an active-high {dp,g..a} pattern.
module hex7seg_decode
  import hex7seg_frame_pkg::*;
(
  input  digit_t     dig,
  output logic [7:0] pat
);
  assign pat = {dig.dp, hex_glyph(dig.nib)};
endmodule

// File: rtl/hex7seg_frame.sv
// Shadow/display frame registers with atomic commit, leading-zero blanking,
// per-digit blink and registered segment outputs for the 4-digit scanner.
module hex7seg_frame
  import hex7seg_frame_pkg::*;
#(
  parameter int BLINK_DIV      = 6000000,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [1:0] wr_addr,
  input  logic [3:0] wr_data,
  input  logic       wr_dp,
  input  logic       commit,
  input  logic [3:0] blink_en,
  input  logic       lzb_en,
  output logic [7:0] seg_a,
  output logic [7:0] seg_b,
  output logic [7:0] seg_c,
  output logic [7:0] seg_d,
  output logic       frame_vld
);
  localparam int CW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
  localparam logic [7:0] SEG_OFF = SEG_ACTIVE_LOW ? ~SEG_OFF_HI : SEG_OFF_HI;

  digit_t [NUM_DIGITS-1:0]       shadow, shadow_nxt, display;
  logic [NUM_DIGITS-1:0][7:0]    glyph, lit, seg_q;
  logic [NUM_DIGITS:0]           lead;
  logic [CW-1:0]                 cnt;
  logic                          phase;
  logic                          vld;

  // A write in the same cycle as a commit is folded into the published frame.
  always_comb begin
    shadow_nxt = shadow;
    if (wr_en) shadow_nxt[wr_addr] = {wr_dp, wr_data};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow  <= '0;
      display <= '0;
      vld     <= 1'b0;
    end else begin
      shadow <= shadow_nxt;
      if (commit) begin
        display <= shadow_nxt;
        vld     <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (cnt == CW'(BLINK_DIV - 1)) begin
      cnt   <= '0;
      phase <= ~phase;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // lead[g] is set while digit g and every digit above it is a blankable zero.
  assign lead[NUM_DIGITS] = lzb_en;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dig
    hex7seg_decode u_dec (.dig(display[g]), .pat(glyph[g]));
    if (g == 0) begin : g_lsd
      assign lead[g] = 1'b0;
    end else begin : g_hi
      assign lead[g] = lead[g+1] & (display[g] == '0);
    end
    assign lit[g] = (!vld || lead[g] || (phase && blink_en[g])) ? SEG_OFF_HI : glyph[g];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seg_q <= {NUM_DIGITS{SEG_OFF}};
    end else begin
      for (int g = 0; g < NUM_DIGITS; g++)
        seg_q[g] <= SEG_ACTIVE_LOW ? ~lit[g] : lit[g];
    end
  end

  assign seg_a     = seg_q[0];
  assign seg_b     = seg_q[1];
  assign seg_c     = seg_q[2];
  assign seg_d     = seg_q[3];
  assign frame_vld = vld;
endmodule

// File: tb/tb_hex7seg_frame.sv
// Bench for hex7seg_frame, instantiated with BLINK_DIV=4 and active-low segments.
// It applies a table of directed vectors, hand sequences for blink and reset, and random traffic against a frame-level model.
module tb_hex7seg_frame;
  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       rst, wr_en, wr_dp, commit, lzb_en;
  logic [1:0] wr_addr;
  logic [3:0] wr_data, blink_en;
  logic [7:0] seg_a, seg_b, seg_c, seg_d;
  logic       frame_vld;

  hex7seg_frame #(.BLINK_DIV(DIV), .SEG_ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_dp(wr_dp), .commit(commit), .blink_en(blink_en), .lzb_en(lzb_en),
    .seg_a(seg_a), .seg_b(seg_b), .seg_c(seg_c), .seg_d(seg_d), .frame_vld(frame_vld)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Frame-level reference model.
  logic [6:0] gl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                          7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  logic [3:0] sn [4], dn [4];
  logic       sd [4], dd [4];
  logic       mv;
  logic [7:0] es [4];
  int         edges;

  task automatic model_edge();
    bit blk [4];
    bit ph;
    logic [7:0] pat;
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        sn[i] = 0; sd[i] = 0; dn[i] = 0; dd[i] = 0; es[i] = 8'hFF;
      end
      mv = 0; edges = 0;
    end else begin
      ph = ((edges / DIV) % 2) == 1;
      for (int i = 0; i < 4; i++) blk[i] = 0;
      if (lzb_en)
        for (int i = 3; i >= 1; i--) begin
          if (dn[i] == 0 && !dd[i]) blk[i] = 1;
          else break;
        end
      for (int i = 0; i < 4; i++) begin
        pat = {dd[i], gl[dn[i]]};
        if (!mv || blk[i] || (ph && blink_en[i])) pat = 8'h00;
        es[i] = ~pat;
      end
      edges++;
      if (wr_en) begin sn[wr_addr] = wr_data; sd[wr_addr] = wr_dp; end
      if (commit) begin
        for (int i = 0; i < 4; i++) begin dn[i] = sn[i]; dd[i] = sd[i]; end
        mv = 1;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("model seg_a", seg_a, es[0]);
    chk("model seg_b", seg_b, es[1]);
    chk("model seg_c", seg_c, es[2]);
    chk("model seg_d", seg_d, es[3]);
    chk("model frame_vld", {7'b0, frame_vld}, {7'b0, mv});
  endtask

  task automatic idle_in();
    wr_en = 0; wr_addr = 0; wr_data = 0; wr_dp = 0; commit = 0;
  endtask

  typedef struct {
    logic       we;
    logic [1:0] addr;
    logic [3:0] data;
    logic       dp;
    logic       cm;
    logic       lzb;
    logic [7:0] ea, eb, ec, ed;
    logic       ev;
  } vec_t;

  vec_t tbl [17];
  logic [7:0] sa_hist [16];

  initial begin
    // Each row lists inputs held for one edge, then the outputs expected just after that edge.
    tbl[0]  = '{1, 0, 4'h1, 0, 0, 0, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 0};
    tbl[1]  = '{1, 1, 4'h2, 0, 0, 0, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 0};
    tbl[2]  = '{1, 2, 4'h3, 0, 0, 0, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 0};
    tbl[3]  = '{1, 3, 4'h4, 0, 0, 0, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 0};
    tbl[4]  = '{0, 0, 4'h0, 0, 1, 0, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 1};
    tbl[5]  = '{0, 0, 4'h0, 0, 0, 0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 1};
    tbl[6]  = '{1, 3, 4'h9, 0, 0, 0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 1};
    tbl[7]  = '{0, 0, 4'h0, 0, 0, 0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 1};
    tbl[8]  = '{1, 0, 4'hA, 0, 1, 0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 1};
    tbl[9]  = '{0, 0, 4'h0, 0, 0, 0, 8'h88, 8'hA4, 8'hB0, 8'h90, 1};
    tbl[10] = '{1, 3, 4'h0, 0, 0, 1, 8'h88, 8'hA4, 8'hB0, 8'h90, 1};
    tbl[11] = '{1, 2, 4'h0, 0, 0, 1, 8'h88, 8'hA4, 8'hB0, 8'h90, 1};
    tbl[12] = '{1, 1, 4'h0, 0, 0, 1, 8'h88, 8'hA4, 8'hB0, 8'h90, 1};
    tbl[13] = '{1, 0, 4'h5, 0, 1, 1, 8'h88, 8'hA4, 8'hB0, 8'h90, 1};
    tbl[14] = '{0, 0, 4'h0, 0, 0, 1, 8'h92, 8'hFF, 8'hFF, 8'hFF, 1};
    tbl[15] = '{1, 2, 4'h0, 1, 1, 1, 8'h92, 8'hFF, 8'hFF, 8'hFF, 1};
    tbl[16] = '{0, 0, 4'h0, 0, 0, 1, 8'h92, 8'hC0, 8'h40, 8'hFF, 1};

    idle_in(); blink_en = 0; lzb_en = 0; rst = 1;
    step(); step();
    rst = 0;

    // State after reset, then idle.
    for (int i = 0; i < 10; i++) step();
    chk("reset seg_a", seg_a, 8'hFF);
    chk("reset seg_d", seg_d, 8'hFF);
    chk("reset frame_vld", {7'b0, frame_vld}, 8'h00);

    // Directed vectors: digit writes, commit latency, write merged into commit, leading-zero blanking and dp.
    foreach (tbl[k]) begin
      wr_en = tbl[k].we; wr_addr = tbl[k].addr; wr_data = tbl[k].data;
      wr_dp = tbl[k].dp; commit = tbl[k].cm; lzb_en = tbl[k].lzb;
      step();
      chk($sformatf("tbl%0d seg_a", k), seg_a, tbl[k].ea);
      chk($sformatf("tbl%0d seg_b", k), seg_b, tbl[k].eb);
      chk($sformatf("tbl%0d seg_c", k), seg_c, tbl[k].ec);
      chk($sformatf("tbl%0d seg_d", k), seg_d, tbl[k].ed);
      chk($sformatf("tbl%0d frame_vld", k), {7'b0, frame_vld}, {7'b0, tbl[k].ev});
    end
    idle_in();

    // Blink on digit 0 only: over 16 cycles seg_a spends 8 cycles off, and each run between toggles lasts 4 cycles.
    blink_en = 4'b0001;
    step();
    for (int i = 0; i < 16; i++) begin
      step();
      sa_hist[i] = seg_a;
      chk("blink seg_c steady", seg_c, 8'h40);
    end
    begin
      int offs, last, bad, nchg;
      offs = 0; last = -1; bad = 0; nchg = 0;
      for (int i = 0; i < 16; i++) begin
        if (sa_hist[i] == 8'hFF) offs++;
        else if (sa_hist[i] != 8'h92) bad++;
        if (i > 0 && sa_hist[i] != sa_hist[i-1]) begin
          if (last >= 0 && i - last != DIV) bad++;
          last = i; nchg++;
        end
      end
      chk("blink off cycles", 8'(offs), 8'd8);
      chk("blink run length", 8'(bad), 8'd0);
      chk("blink toggles", 8'(nchg >= 3), 8'd1);
    end
    blink_en = 0;

    // Reset in the same cycle as a write and a commit: both are discarded.
    rst = 1; wr_en = 1; wr_addr = 0; wr_data = 4'hF; wr_dp = 1; commit = 1; lzb_en = 0;
    step();
    rst = 0; idle_in();
    chk("rst seg_a", seg_a, 8'hFF);
    chk("rst seg_b", seg_b, 8'hFF);
    chk("rst frame_vld", {7'b0, frame_vld}, 8'h00);
    step();
    commit = 1; step(); commit = 0;
    chk("rst commit vld", {7'b0, frame_vld}, 8'h01);
    step();
    chk("rst shadow d0", seg_a, 8'hC0);
    chk("rst shadow d3", seg_d, 8'hC0);
    step();
    chk("republish d0", seg_a, 8'hC0);

    // Random traffic checked against the model.
    for (int n = 0; n < 3000; n++) begin
      rst     = ($urandom_range(0, 199) == 0);
      wr_en   = $urandom_range(0, 1);
      wr_addr = 2'($urandom);
      wr_data = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
      wr_dp   = ($urandom_range(0, 3) == 0);
      commit  = ($urandom_range(0, 7) == 0);
      if (n % 50 == 0) blink_en = 4'($urandom);
      if (n % 37 == 0) lzb_en = $urandom_range(0, 1);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
